// File: rtl/ldpc_wb_seq_master.sv
// Wishbone classic initiator that runs one LDPC CSR transaction:
// message write, start pulse, status poll, codeword readback.
module ldpc_wb_seq_master #(
  parameter logic [31:0] BASE_ADDR   = 32'h3001_0000,
  parameter int          MSG_BITS    = 40,
  parameter int          CW_BITS     = 208,
  parameter logic [12:0] MSG_OFF     = 13'h000,
  parameter logic [12:0] CTRL_OFF    = 13'h040,
  parameter logic [12:0] STAT_OFF    = 13'h044,
  parameter logic [12:0] RES_OFF     = 13'h080,
  parameter int          ACK_TIMEOUT = 64,
  parameter int          POLL_MAX    = 1024
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [MSG_BITS-1:0] cmd_msg,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [3:0]          wbm_sel_o,
  output logic [31:0]         wbm_adr_o,
  output logic [31:0]         wbm_dat_o,
  input  logic [31:0]         wbm_dat_i,
  input  logic                wbm_ack_i,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [CW_BITS-1:0]  rsp_cword,
  output logic                rsp_pass,
  output logic                rsp_timeout,
  output logic                busy
);

  localparam int NW = (MSG_BITS + 31) / 32;
  localparam int NR = (CW_BITS + 31) / 32;
  localparam int MW = NW * 32;
  localparam int IW = $clog2((NW > NR ? NW : NR) + 1);
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WR_MSG, START1, START0, POLL, RD_RES, RESP
  } state_t;

  state_t        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [MW-1:0] msg_q, msg_d;
  logic          pass_q, pass_d;
  logic          tout_q, tout_d;
  logic          cap, clr;
  logic [31:0]   woff;

  assign woff = 32'(idx_q) << 2;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      idx_q   <= '0;
      poll_q  <= '0;
      tcnt_q  <= '0;
      msg_q   <= '0;
      pass_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      idx_q   <= idx_d;
      poll_q  <= poll_d;
      tcnt_q  <= tcnt_d;
      msg_q   <= msg_d;
      pass_q  <= pass_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    idx_d   = idx_q;
    poll_d  = poll_q;
    tcnt_d  = tcnt_q;
    msg_d   = msg_q;
    pass_d  = pass_q;
    tout_d  = tout_q;
    cap     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          msg_d   = MW'(cmd_msg);
          idx_d   = '0;
          poll_d  = '0;
          tcnt_d  = '0;
          pass_d  = 1'b0;
          tout_d  = 1'b0;
          clr     = 1'b1;
          state_d = WR_MSG;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: begin
        if (!cyc_q) begin
          // bus idle for a cycle: launch this state's transfer
          cyc_d  = 1'b1;
          tcnt_d = '0;
          we_d   = 1'b1;
          dat_d  = 32'h0;
          case (state_q)
            WR_MSG: begin
              adr_d = BASE_ADDR + 32'(MSG_OFF) + woff;
              dat_d = msg_q[31:0];
            end
            START1: begin
              adr_d = BASE_ADDR + 32'(CTRL_OFF);
              dat_d = 32'h1;
            end
            START0: adr_d = BASE_ADDR + 32'(CTRL_OFF);
            POLL: begin
              we_d  = 1'b0;
              adr_d = BASE_ADDR + 32'(STAT_OFF);
            end
            default: begin
              we_d  = 1'b0;
              adr_d = BASE_ADDR + 32'(RES_OFF) + woff;
            end
          endcase
        end else if (wbm_ack_i) begin
          cyc_d  = 1'b0;
          tcnt_d = '0;
          case (state_q)
            WR_MSG: begin
              msg_d = msg_q >> 32;
              if (idx_q == IW'(NW - 1)) begin
                idx_d   = '0;
                state_d = START1;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
            START1: state_d = START0;
            START0: state_d = POLL;
            POLL: begin
              poll_d = poll_q + 1'b1;
              if (wbm_dat_i[0]) begin
                pass_d  = wbm_dat_i[1];
                idx_d   = '0;
                state_d = RD_RES;
              end else if (poll_d == PW'(POLL_MAX)) begin
                tout_d  = 1'b1;
                state_d = RESP;
              end
            end
            default: begin
              cap = 1'b1;
              if (idx_q == IW'(NR - 1)) state_d = RESP;
              else idx_d = idx_q + 1'b1;
            end
          endcase
        end else if (tcnt_q == TW'(ACK_TIMEOUT - 1)) begin
          cyc_d   = 1'b0;
          tout_d  = 1'b1;
          pass_d  = 1'b0;
          state_d = RESP;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
    endcase
  end

  // per-word capture; the top word keeps only the bits inside CW_BITS
  for (genvar k = 0; k < NR; k++) begin : g_res
    localparam int LO = k * 32;
    localparam int HI = (LO + 31 < CW_BITS) ? LO + 31 : CW_BITS - 1;
    logic [HI-LO:0] w_q;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) w_q <= '0;
      else if (clr) w_q <= '0;
      else if (cap && idx_q == IW'(k)) w_q <= wbm_dat_i[HI-LO:0];
    end
    assign rsp_cword[HI:LO] = w_q;
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_pass    = pass_q;
  assign rsp_timeout = tout_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_sel_o   = {4{cyc_q}};
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;

endmodule

// File: tb/tb_ldpc_wb_seq_master.sv
// Scoreboard bench for ldpc_wb_seq_master: expected bus transfers and
// responses are queued by the stimulus and checked by the slave/monitor.
module tb_ldpc_wb_seq_master;

  localparam logic [31:0] BASE = 32'h3001_0000;
  localparam int CWB = 208;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [39:0]    cmd_msg;
  logic           wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]     wbm_sel_o;
  logic [31:0]    wbm_adr_o, wbm_dat_o;
  logic [31:0]    wbm_dat_i = 32'h0;
  logic           wbm_ack_i = 1'b0;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [CWB-1:0] rsp_cword;
  logic           rsp_pass, rsp_timeout, busy;

  always #5 clk = ~clk;

  ldpc_wb_seq_master #(.POLL_MAX(8)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_msg    (cmd_msg),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_ack_i  (wbm_ack_i),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_cword  (rsp_cword),
    .rsp_pass   (rsp_pass),
    .rsp_timeout(rsp_timeout),
    .busy       (busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_t;

  typedef struct {
    logic [CWB-1:0] cw;
    logic           pass;
    logic           tout;
  } rsp_t;

  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  bus_t eb;
  rsp_t er;

  int n_chk = 0;
  int n_fail = 0;
  int n_rsp = 0;

  // slave configuration and observation
  int          lat = 0;
  bit          hold_ctrl = 1'b0;
  bit          chk_tmo = 1'b0;
  int          zero_n = 0;
  logic [31:0] stat_fin = 32'h3;
  logic [31:0] res_base = 32'h0;
  int          n_stat = 0;
  int          n_res = 0;
  int          n_tmo = 0;
  int          wcnt = 0;
  bit          acked = 1'b0;
  logic [31:0] a0, d0;
  logic        we0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic pw(input logic [31:0] off, input logic [31:0] d);
    bus_t b;
    b.we = 1'b1; b.adr = BASE + off; b.dat = d;
    exp_bus.push_back(b);
  endtask

  task automatic pr(input logic [31:0] off);
    bus_t b;
    b.we = 1'b0; b.adr = BASE + off; b.dat = 32'h0;
    exp_bus.push_back(b);
  endtask

  task automatic push_head(input logic [39:0] m, input int polls);
    pw(32'h00, m[31:0]);
    pw(32'h04, {24'h0, m[39:32]});
    pw(32'h40, 32'h1);
    pw(32'h40, 32'h0);
    for (int i = 0; i < polls; i++) pr(32'h44);
  endtask

  task automatic push_res(input int n);
    for (int k = 0; k < n; k++) pr(32'h80 + 32'(k * 4));
  endtask

  task automatic push_rsp(input logic [CWB-1:0] cw, input logic p,
                          input logic t);
    rsp_t r;
    r.cw = cw; r.pass = p; r.tout = t;
    exp_rsp.push_back(r);
  endtask

  function automatic logic [CWB-1:0] mk_cw(input logic [31:0] base);
    logic [223:0] t;
    for (int k = 0; k < 7; k++) t[k*32 +: 32] = base + 32'(k);
    return t[CWB-1:0];
  endfunction

  task automatic send(input logic [39:0] m);
    int t = 0;
    while (!cmd_ready && t < 500) begin
      @(posedge clk); #1; t++;
    end
    chk("cmd_ready_wait", {255'h0, cmd_ready}, 256'h1);
    cmd_msg = m;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int t = 0;
    while (n_rsp < target && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    chk("rsp_arrived", {255'h0, n_rsp >= target}, 256'h1);
    @(posedge clk); #1;
  endtask

  // responding slave and bus monitor
  always @(negedge clk) begin
    if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
      if (wcnt == 0) begin
        a0 = wbm_adr_o; d0 = wbm_dat_o; we0 = wbm_we_o;
      end
      wcnt++;
      if (!(hold_ctrl && wbm_we_o && wbm_adr_o == BASE + 32'h40 &&
            wbm_dat_o == 32'h1) && wcnt > lat) begin
        if (!wbm_we_o && wbm_adr_o == BASE + 32'h44) begin
          n_stat++;
          wbm_dat_i = (n_stat > zero_n) ? stat_fin : 32'h0;
        end else if (!wbm_we_o && wbm_adr_o >= BASE + 32'h80 &&
                     wbm_adr_o < BASE + 32'h9C) begin
          n_res++;
          wbm_dat_i = res_base + ((wbm_adr_o - BASE - 32'h80) >> 2);
        end else begin
          wbm_dat_i = 32'h0;
        end
        wbm_ack_i = 1'b1;
        acked = 1'b1;
        if (exp_bus.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL bus_extra: got adr %0h we %0b, required none",
                   wbm_adr_o, wbm_we_o);
        end else begin
          eb = exp_bus.pop_front();
          chk("bus_we", {255'h0, wbm_we_o}, {255'h0, eb.we});
          chk("bus_adr", {224'h0, wbm_adr_o}, {224'h0, eb.adr});
          if (eb.we) chk("bus_wdat", {224'h0, wbm_dat_o}, {224'h0, eb.dat});
          chk("bus_sel", {252'h0, wbm_sel_o}, 256'hF);
          chk("bus_stable", {191'h0, wbm_we_o, wbm_adr_o, wbm_dat_o},
              {191'h0, we0, a0, d0});
        end
      end
    end else begin
      if (!wbm_cyc_o && wcnt != 0 && !acked && chk_tmo) begin
        n_tmo++;
        chk("ack_timeout_len", 256'(wcnt), 256'd64);
      end
      wbm_ack_i = 1'b0;
      wcnt = 0;
      acked = 1'b0;
    end
  end

  // response monitor
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      n_rsp++;
      if (exp_rsp.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rsp_extra: got cword %0h, required none", rsp_cword);
      end else begin
        er = exp_rsp.pop_front();
        chk("rsp_cword", {48'h0, rsp_cword}, {48'h0, er.cw});
        chk("rsp_pass", {255'h0, rsp_pass}, {255'h0, er.pass});
        chk("rsp_timeout", {255'h0, rsp_timeout}, {255'h0, er.tout});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_msg = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {255'h0, cmd_ready}, 256'h1);
    chk("rst_busy", {255'h0, busy}, 256'h0);
    chk("rst_cyc_stb", {254'h0, wbm_cyc_o, wbm_stb_o}, 256'h0);
    chk("rst_sel_adr", {220'h0, wbm_sel_o, wbm_adr_o}, 256'h0);
    chk("rst_rsp", {253'h0, rsp_valid, rsp_pass, rsp_timeout}, 256'h0);
    chk("rst_cword", {48'h0, rsp_cword}, 256'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic decode
    lat = 0; zero_n = 0; stat_fin = 32'h3; res_base = 32'h1000_0000;
    n_stat = 0; n_res = 0;
    push_head(40'hA5_1234_5678, 1);
    push_res(7);
    push_rsp(mk_cw(32'h1000_0000), 1'b1, 1'b0);
    send(40'hA5_1234_5678);
    wait_rsp(1);
    chk("basic_stat_reads", 256'(n_stat), 256'd1);
    chk("basic_res_reads", 256'(n_res), 256'd7);

    // slow poll
    zero_n = 5; stat_fin = 32'h1; res_base = 32'h2000_0000;
    n_stat = 0; n_res = 0;
    push_head(40'h3C_0BAD_F00D, 6);
    push_res(7);
    push_rsp(mk_cw(32'h2000_0000), 1'b0, 1'b0);
    send(40'h3C_0BAD_F00D);
    wait_rsp(2);
    chk("slow_stat_reads", 256'(n_stat), 256'd6);

    // poll limit
    zero_n = 1000; n_stat = 0; n_res = 0;
    push_head(40'h00_0000_0001, 8);
    push_rsp('0, 1'b0, 1'b1);
    send(40'h00_0000_0001);
    wait_rsp(3);
    chk("limit_stat_reads", 256'(n_stat), 256'd8);
    chk("limit_res_reads", 256'(n_res), 256'd0);

    // ack timeout on the start write
    hold_ctrl = 1'b1; chk_tmo = 1'b1; n_tmo = 0; n_stat = 0;
    pw(32'h00, 32'hFFFF_FFFF);
    pw(32'h04, 32'h0000_00FF);
    push_rsp('0, 1'b0, 1'b1);
    send(40'hFF_FFFF_FFFF);
    wait_rsp(4);
    chk("tmo_seen", 256'(n_tmo), 256'd1);
    chk("tmo_stat_reads", 256'(n_stat), 256'd0);
    hold_ctrl = 1'b0; chk_tmo = 1'b0;

    // clean follow-up
    zero_n = 0; stat_fin = 32'h3; res_base = 32'h3000_0000;
    push_head(40'h01_0000_0002, 1);
    push_res(7);
    push_rsp(mk_cw(32'h3000_0000), 1'b1, 1'b0);
    send(40'h01_0000_0002);
    chk("follow_busy", {255'h0, busy}, 256'h1);
    chk("follow_flags", {254'h0, rsp_timeout, rsp_pass}, 256'h0);
    wait_rsp(5);

    // wait states, back-pressure, cmd_valid while busy
    lat = 3; zero_n = 1; stat_fin = 32'h3; res_base = 32'h4000_0000;
    n_stat = 0;
    rsp_ready = 1'b0;
    push_head(40'h7E_C0DE_CAFE, 2);
    push_res(7);
    push_rsp(mk_cw(32'h4000_0000), 1'b1, 1'b0);
    send(40'h7E_C0DE_CAFE);
    cmd_msg = 40'h11_1111_1111;
    cmd_valid = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    begin
      int t = 0;
      while (!rsp_valid && t < 3000) begin
        @(posedge clk); #1; t++;
      end
    end
    chk("bp_valid_seen", {255'h0, rsp_valid}, 256'h1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_held", {254'h0, rsp_valid, cmd_ready}, 256'h2);
    end
    rsp_ready = 1'b1;
    wait_rsp(6);
    chk("bp_stat_reads", 256'(n_stat), 256'd2);

    // reset during result word 3
    lat = 3; zero_n = 0; stat_fin = 32'h3; res_base = 32'h5000_0000;
    n_res = 0;
    push_head(40'h00_0000_0003, 1);
    push_res(3);
    send(40'h00_0000_0003);
    begin
      int t = 0;
      while (!(wbm_cyc_o && wbm_adr_o == BASE + 32'h8C) && t < 3000) begin
        @(posedge clk); #1; t++;
      end
    end
    chk("rr_word3_seen", {224'h0, wbm_adr_o}, {224'h0, BASE + 32'h8C});
    rst = 1'b1;
    #1;
    chk("rr_cyc_stb_drop", {254'h0, wbm_cyc_o, wbm_stb_o}, 256'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rr_idle", {253'h0, cmd_ready, rsp_valid, busy}, 256'h4);
    chk("rr_res_reads", 256'(n_res), 256'd3);
    chk("rr_bus_left", 256'(exp_bus.size()), 256'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("end_bus_queue", 256'(exp_bus.size()), 256'd0);
    chk("end_rsp_queue", 256'(exp_rsp.size()), 256'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
